// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out framing transmitter.
//
// Accepts one WIDTH-bit word per din_valid/din_ready handshake and emits a
// frame on sdo: a start marker (1), then the word MSB-first, one bit per clock.
// With PISO_PARITY_EN defined, an even-parity bit follows the LSB. A single-
// cycle done pulse marks the end of each frame, and frame is high while sdo
// carries a start, data or parity bit. Every output comes straight from a flop.
//
// Optional feature macro: PISO_PARITY_EN (undefined by default, no parity).
//
// Parameters:
//   WIDTH      - data word width in bits (WIDTH >= 2)
//   IDLE_LEVEL - level driven on sdo between frames
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   din        in   parallel word, sampled only on the handshake edge
//   din_valid  in   upstream has a word on din
//   din_ready  out  block can accept a word this cycle
//   sdo        out  serial data out
//   frame      out  high while sdo carries a start/data/parity bit
//   done       out  one-cycle pulse at end of frame

module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sdo,
  output logic             frame,
  output logic             done
);

  localparam int unsigned     CntW   = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
`ifdef PISO_PARITY_EN
    StShift,
    StParity
`else
    StShift
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sdo_q, sdo_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic handshake;

  // ready_q is low for the first edge after reset, so no word can be taken
  // before the block has announced readiness.
  assign handshake = din_valid & ready_q;

  // Outputs are registered one step ahead: each *_d value is what must be
  // visible after the coming edge, derived from the state being entered.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    sdo_d    = IDLE_LEVEL;
    frame_d  = 1'b0;
    done_d   = 1'b0;
    ready_d  = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        if (handshake) begin
          state_d  = StStart;
          shreg_d  = din;
          cnt_d    = CntMax;
`ifdef PISO_PARITY_EN
          parity_d = ^din;
`endif
          sdo_d    = 1'b1;  // start marker
          frame_d  = 1'b1;
          ready_d  = 1'b0;
        end
      end

      StStart: begin
        // Present the MSB and pre-shift so SHIFT always shows shreg_q MSB next.
        state_d = StShift;
        sdo_d   = shreg_q[WIDTH-1];
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        frame_d = 1'b1;
      end

      StShift: begin
        // cnt_q is the index of the bit currently on sdo.
        if (cnt_q == '0) begin
`ifdef PISO_PARITY_EN
          state_d = StParity;
          sdo_d   = parity_q;
          frame_d = 1'b1;
`else
          state_d = StIdle;
          done_d  = 1'b1;
          ready_d = 1'b1;
`endif
        end else begin
          cnt_d   = cnt_q - CntW'(1);
          sdo_d   = shreg_q[WIDTH-1];
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          frame_d = 1'b1;
        end
      end

`ifdef PISO_PARITY_EN
      StParity: begin
        state_d = StIdle;
        done_d  = 1'b1;
        ready_d = 1'b1;
      end
`endif

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      cnt_q    <= '0;
      sdo_q    <= IDLE_LEVEL;
      frame_q  <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      sdo_q    <= sdo_d;
      frame_q  <= frame_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign sdo       = sdo_q;
  assign frame     = frame_q;
  assign done      = done_q;
  assign din_ready = ready_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed testbench for piso_serializer (WIDTH=8, IDLE_LEVEL=0).

module tb_piso_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sdo;
  logic       frame;
  logic       done;

  int checks;
  int failures;
  int hs_cnt;
  int done_cnt;

  piso_serializer #(
    .WIDTH      (8),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sdo       (sdo),
    .frame     (frame),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake and done-pulse counters, sampled on the active edge.
  always @(posedge clk) begin
    if (din_valid && din_ready) hs_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic e_sdo, input logic e_frame,
                          input logic e_done, input logic e_ready);
    chk({tag, ".sdo"}, 32'(sdo), 32'(e_sdo));
    chk({tag, ".frame"}, 32'(frame), 32'(e_frame));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".ready"}, 32'(din_ready), 32'(e_ready));
  endtask

  // Called #1 after the handshake edge; returns #1 after the done edge.
  // With wiggle set, din_valid toggles and din is changed every frame cycle.
  task automatic expect_frame(input logic [7:0] w, input bit wiggle, input string tag);
    chk_outs({tag, ".start"}, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      if (wiggle) begin
        din_valid = ~din_valid;
        din       = 8'h3C;
      end
      tick();
      chk_outs($sformatf("%s.d%0d", tag, i), w[i], 1'b1, 1'b0, 1'b0);
    end
`ifdef PISO_PARITY_EN
    if (wiggle) din_valid = ~din_valid;
    tick();
    chk_outs({tag, ".par"}, ^w, 1'b1, 1'b0, 1'b0);
`endif
    tick();
    chk_outs({tag, ".end"}, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    hs_cnt    = 0;
    done_cnt  = 0;
    reset     = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;

    // 1: reset held for 3 cycles, ready one edge after release.
    #1;
    chk_outs("rst0", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_outs($sformatf("rst%0d", i + 1), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    #1;
    chk("rel.ready_pre", 32'(din_ready), 32'd0);
    tick();
    chk_outs("rel", 1'b0, 1'b0, 1'b0, 1'b1);

    // 2: single A5 word with one-cycle valid.
    din       = 8'hA5;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    expect_frame(8'hA5, 1'b0, "a5");
    tick();
    chk_outs("a5.after", 1'b0, 1'b0, 1'b0, 1'b1);

    // 3: FF then 00 with valid held high.
    hs_cnt   = 0;
    done_cnt = 0;
    din       = 8'hFF;
    din_valid = 1'b1;
    tick();
    din = 8'h00;
    expect_frame(8'hFF, 1'b0, "ff");
    tick();
    expect_frame(8'h00, 1'b0, "b2b00");
    din_valid = 1'b0;
    tick();
    chk("b2b.done_gone", 32'(done), 32'd0);
    chk("b2b.handshakes", 32'(hs_cnt), 32'd2);
    chk("b2b.done_pulses", 32'(done_cnt), 32'd2);

    // 4: A5 frame with din/din_valid disturbed mid-frame, then 3C.
    hs_cnt    = 0;
    din       = 8'hA5;
    din_valid = 1'b1;
    tick();
    expect_frame(8'hA5, 1'b1, "a5wig");
    din       = 8'h3C;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    expect_frame(8'h3C, 1'b0, "3c");
    chk("wig.handshakes", 32'(hs_cnt), 32'd2);

    // 5: reset asserted while the 4th data bit is on sdo.
    tick();
    done_cnt  = 0;
    din       = 8'h5A;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk_outs("abort.pre", 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_outs("abort.now", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk_outs("abort.held", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    chk_outs("abort.rel", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("abort.no_done", 32'(done_cnt), 32'd0);
    din       = 8'hC3;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    expect_frame(8'hC3, 1'b0, "c3");
    chk("abort.one_done", 32'(done_cnt), 32'd0);
    tick();
    chk("abort.done_cnt", 32'(done_cnt), 32'd1);

    // 6: odd-parity word (parity bit checked only when the feature is built).
    din       = 8'h07;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    expect_frame(8'h07, 1'b0, "07");
    tick();
    chk_outs("07.after", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
